// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings, legal parameter ranges.
package uart_pkg;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 1;
    localparam int OVERSAMPLE_MAX = 64;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // 2'b11 is reserved and behaves like PAR_NONE
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversample ticks and flags the tick that closes a bit period.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic uart_tick,
    output logic bit_end
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] r_tick_cnt;
    logic          w_last;

    assign w_last  = (r_tick_cnt == LAST);
    // clear wins over a coincident tick, so that tick never ends a bit
    assign bit_end = uart_tick & w_last & ~clear;

    // tick counter, wraps after OVERSAMPLE ticks
    always_ff @(posedge clock) begin
        if (!reset || clear)
            r_tick_cnt <= '0;
        else if (uart_tick)
            r_tick_cnt <= w_last ? '0 : r_tick_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, per-frame parity and stop count.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic                 tx_signal
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_param
        $error("uart_tx_cfg: DATA_BITS or OVERSAMPLE out of range");
    end

    tx_state_t            r_state, w_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_par_en, r_par_bit, r_stop2;
    logic                 r_tx, w_tx_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_accept, w_bit_end, w_idle;

    assign w_idle     = (r_state == IDLE);
    assign w_accept   = tx_valid & w_idle;
    assign tx_ready   = w_idle;
    assign tx_busy    = ~w_idle;
    assign frame_done = r_done;
    assign tx_signal  = r_tx;

    // held clear in IDLE: ticks there, including the accept cycle, are ignored
    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_idle),
        .uart_tick (uart_tick),
        .bit_end   (w_bit_end)
    );

    // state register
    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next-state decode; unknown encodings fall back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (tx_valid) w_next = START;
            START:  if (w_bit_end) w_next = DATA;
            DATA:   if (w_bit_end && r_bit_cnt == LAST_BIT)
                        w_next = r_par_en ? PARITY : STOP;
            PARITY: if (w_bit_end) w_next = STOP;
            STOP:   if (w_bit_end && (!r_stop2 || r_stop_cnt)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // output decode: line level and done pulse follow the next state
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept)
            w_shift_nxt = tx_data;
        else if (r_state == DATA && w_bit_end)
            w_shift_nxt = r_shift >> 1;

        case (w_next)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = r_par_bit;
            default: w_tx_nxt = 1'b1;
        endcase

        w_done_nxt = (r_state == STOP) && (w_next == IDLE);
    end

    // datapath: frame config latched at accept, counters advance on bit ends
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_par_en   <= parity_enabled(cfg_parity);
                r_par_bit  <= (^tx_data) ^ (cfg_parity == PAR_ODD);
                r_stop2    <= cfg_stop2;
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
            end else begin
                if (r_state == DATA && w_bit_end)
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_state == STOP && w_bit_end)
                    r_stop_cnt <= 1'b1;
            end
        end
    end

endmodule
